ro_measure_ctrl: RTL and testbench
==================================

# ro_measure_ctrl

Sequencer that time-shares one ring-oscillator counting circuit among `NUM_RO` ring oscillators. On a start request it walks the enabled oscillators in ascending index order. For each one it selects the oscillator, clears the counter, opens a fixed gate window of `clk` cycles, waits for the counter's synchronizer to drain, and then publishes the 16-bit count. It sits between the software/test register interface and the counting circuit, driving that circuit's select, clear and enable controls.

## Interface
- `NUM_RO`, 4: number of ring oscillators sharing the counter (2..16).
- `CNT_W`, 16: width of the counter value.
- `WINDOW`, 1024: gate length in `clk` cycles (≥1).
- `SETTLE`, 4: cycles with clear held after a select change (≥1).
- `DRAIN`, 2: idle cycles after the gate closes, before sampling (≥0).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to begin a sweep; ignored while `busy`.
- `abort` in 1: terminates a sweep immediately.
- `ro_mask` in NUM_RO: oscillators to measure; sampled only on an accepted `start`.
- `cnt_value` in CNT_W: count from the counting circuit.
- `ro_sel` out clog2(NUM_RO): oscillator select to the ring mux.
- `cnt_clear` out 1: synchronous clear to the counter.
- `cnt_enable` out 1: gate; the counter increments only while high.
- `busy` out 1: a sweep is in progress.
- `result_valid` out 1: one-cycle strobe; `result_idx`/`result_data`/`result_ovf` are valid.
- `result_idx` out clog2(NUM_RO): oscillator index of the result.
- `result_data` out CNT_W: captured count.
- `result_ovf` out 1: captured count equals all-ones (saturated or wrapped; treat as invalid).
- `done` out 1: one-cycle strobe at the end of a sweep.

## Operation
- Reset values: all outputs are 0, the state is IDLE, and the latched mask is 0.
- States are IDLE, SETTLE, COUNT, DRAIN and CAPTURE.
- IDLE:
  - `start` with `ro_mask != 0`: latch the mask, load `ro_sel` with the lowest set index, go to SETTLE.
  - `start` with `ro_mask == 0`: pulse `done` on the next cycle and stay in IDLE (`busy` is never raised).
- SETTLE: `cnt_clear=1` for exactly `SETTLE` cycles, then go to COUNT.
- COUNT: `cnt_enable=1` for exactly `WINDOW` cycles, then go to DRAIN. If `DRAIN==0`, go directly to CAPTURE.
- DRAIN: clear and enable are both low for `DRAIN` cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - Register `result_data=cnt_value` and `result_idx=ro_sel`.
  - Set `result_ovf=(cnt_value=={CNT_W{1'b1}})` and pulse `result_valid` on the following cycle.
  - If a set mask bit exists above `ro_sel`, load that index and go to SETTLE.
  - Otherwise pulse `done` and go to IDLE.
- `busy` is 1 in every state except IDLE.
- `ro_sel` changes only on entry to SETTLE and holds its value in IDLE after a sweep.
- Abort:
  - `abort` in any non-IDLE state: next cycle is IDLE, `cnt_enable`/`cnt_clear` drop to 0, and no `result_valid` or `done` is issued.
  - `abort` in IDLE has no effect.
  - `abort` and `start` in the same IDLE cycle: `start` wins.
- `start` while `busy` is ignored, with no queuing.
- The mask latch is unaffected by `ro_mask` changes during a sweep.
- An `rst_n` assertion mid-sweep forces reset values asynchronously. The counter is left in an undefined state, and the next sweep's SETTLE clears it.

## Timing
- All outputs are registered.
- `start` accepted at edge 0: `busy`, `cnt_clear` and `ro_sel` are valid after edge 1.
- Per oscillator, `cnt_enable` is high for exactly `WINDOW` consecutive cycles.
- Oscillator period = `SETTLE+WINDOW+DRAIN+1` cycles. `result_valid` rises `SETTLE+WINDOW+DRAIN+1` cycles after SETTLE entry.
- Full sweep of k enabled oscillators = k·(SETTLE+WINDOW+DRAIN+1) cycles from the first SETTLE cycle.
- `done` is asserted in the same cycle as the final `result_valid`. `busy` falls in that same cycle.
- A new `start` is accepted in the cycle after `done`.

## Structure
- Package `ro_meas_pkg`:
  - state enum `ro_state_t` (IDLE, SETTLE, COUNT, DRAIN, CAPTURE);
  - default constants `RO_CNT_W=16`, `RO_WINDOW_DEF=1024`;
  - function `next_set_idx(mask, cur)` returning the lowest set index above `cur` plus a found flag.
- Sub-module `ro_window_timer`: loadable down-counter sized clog2(max(WINDOW,SETTLE,DRAIN)+1), with `load`/`value` inputs and an `expire` output. It is shared by SETTLE, COUNT and DRAIN.

## Test plan
Bench parameters are `NUM_RO=4`, `WINDOW=16`, `SETTLE=4`, `DRAIN=2`, giving 23 cycles per oscillator.
- Full sweep: `start` with `ro_mask=4'b1111` and counter model returning idx·100 → results idx 0..3 with data 0/100/200/300, 23 cycles apart. `done` comes with the 4th result, and `cnt_enable` is high for exactly 16 cycles per oscillator.
- Sparse mask: `ro_mask=4'b1010` → exactly two results, idx 1 then 3. `ro_sel` never takes 0 or 2, and `done` arrives 46 cycles after the first SETTLE cycle.
- Empty mask: `start` with `ro_mask=0` → `done` on the next cycle, `busy` stays 0, no `result_valid`.
- Abort in COUNT during the second oscillator → IDLE next cycle, `cnt_enable=0`, exactly one result (idx 0), no `done`. A following `start` runs a full sweep.
- Overflow and busy start: counter model returns 16'hFFFF for idx 2 → `result_ovf=1` only for idx 2. A `start` pulse with a changed mask mid-sweep → ignored, original mask used.
- Reset: `rst_n` low mid-COUNT → all outputs 0 immediately (asynchronous). After release, the block stays in IDLE until `start`.

Source files
------------

// File: rtl/ro_measure_ctrl_pkg.sv
// Shared types, defaults and mask-search helper for the ring-oscillator measurement sequencer.
package ro_meas_pkg;

   localparam int unsigned RO_CNT_W      = 16;
   localparam int unsigned RO_WINDOW_DEF = 1024;
   localparam int unsigned RO_MAX        = 16;

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StCount,
      StDrain,
      StCapture
   } ro_state_t;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } ro_next_t;

   // Lowest set bit strictly above cur; pass cur = -1 to search from bit 0.
   function automatic ro_next_t next_set_idx(input logic [RO_MAX-1:0] mask, input int cur);
      ro_next_t res;
      res = '0;
      for (int i = RO_MAX - 1; i >= 0; i--) begin
         if (mask[i] && (i > cur)) begin
            res.found = 1'b1;
            res.idx   = 4'(i);
         end
      end
      return res;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ro_measure_ctrl_if.sv
// Register-side request/result signals and counting-circuit controls of the sequencer.
interface ro_measure_ctrl_if #(
   parameter int unsigned NUM_RO = 4,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned SEL_W = $clog2(NUM_RO);

   logic              start;
   logic              abort;
   logic [NUM_RO-1:0] ro_mask;
   logic [CNT_W-1:0]  cnt_value;
   logic [SEL_W-1:0]  ro_sel;
   logic              cnt_clear;
   logic              cnt_enable;
   logic              busy;
   logic              result_valid;
   logic [SEL_W-1:0]  result_idx;
   logic [CNT_W-1:0]  result_data;
   logic              result_ovf;
   logic              done;

   modport master (
      output start, abort, ro_mask, cnt_value,
      input  ro_sel, cnt_clear, cnt_enable, busy, result_valid, result_idx, result_data,
             result_ovf, done
   );

   modport slave (
      input  start, abort, ro_mask, cnt_value,
      output ro_sel, cnt_clear, cnt_enable, busy, result_valid, result_idx, result_data,
             result_ovf, done
   );

endinterface

// File: rtl/ro_window_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module ro_window_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_expire
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - WIDTH'(1);
      end
   end

   assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/ro_measure_ctrl.sv
// Sweeps enabled ring oscillators through one shared counter: settle, gate, drain, capture.
module ro_measure_ctrl
   import ro_meas_pkg::*;
#(
   parameter int unsigned NUM_RO = 4,
   parameter int unsigned CNT_W  = RO_CNT_W,
   parameter int unsigned WINDOW = RO_WINDOW_DEF,
   parameter int unsigned SETTLE = 4,
   parameter int unsigned DRAIN  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   ro_measure_ctrl_if.slave  bus
);

   localparam int unsigned SEL_W = $clog2(NUM_RO);
   localparam int unsigned TMR_W = $clog2(max3(WINDOW, SETTLE, DRAIN) + 1);

   // Timer holds N-1 on state entry so each phase lasts exactly N cycles.
   localparam logic [TMR_W-1:0] LD_SETTLE = TMR_W'(SETTLE - 1);
   localparam logic [TMR_W-1:0] LD_WINDOW = TMR_W'(WINDOW - 1);
   localparam logic [TMR_W-1:0] LD_DRAIN  = TMR_W'((DRAIN > 0) ? DRAIN - 1 : 0);

   ro_state_t         r_state, w_state_nxt;
   logic [NUM_RO-1:0] r_mask, w_mask_nxt;
   logic [SEL_W-1:0]  r_sel, w_sel_nxt;
   logic              r_clear, w_clear_nxt;
   logic              r_enable, w_enable_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_valid, w_valid_nxt;
   logic [SEL_W-1:0]  r_idx, w_idx_nxt;
   logic [CNT_W-1:0]  r_data, w_data_nxt;
   logic              r_ovf, w_ovf_nxt;
   logic              r_done, w_done_nxt;

   logic              w_tmr_load;
   logic [TMR_W-1:0]  w_tmr_value;
   logic              w_tmr_expire;
   logic [RO_MAX-1:0] w_req_ext, w_mask_ext;
   ro_next_t          w_first, w_next;

   ro_window_timer #(
      .WIDTH (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_tmr_load),
      .i_value  (w_tmr_value),
      .o_expire (w_tmr_expire)
   );

   always_comb begin
      w_req_ext               = '0;
      w_req_ext[NUM_RO-1:0]   = bus.ro_mask;
      w_mask_ext              = '0;
      w_mask_ext[NUM_RO-1:0]  = r_mask;
      w_first                 = next_set_idx(w_req_ext, -1);
      w_next                  = next_set_idx(w_mask_ext, int'(r_sel));
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_mask_nxt   = r_mask;
      w_sel_nxt    = r_sel;
      w_clear_nxt  = 1'b0;
      w_enable_nxt = 1'b0;
      w_busy_nxt   = 1'b1;
      w_valid_nxt  = 1'b0;
      w_idx_nxt    = r_idx;
      w_data_nxt   = r_data;
      w_ovf_nxt    = r_ovf;
      w_done_nxt   = 1'b0;
      w_tmr_load   = 1'b0;
      w_tmr_value  = '0;

      unique case (r_state)
         StIdle: begin
            w_busy_nxt = 1'b0;
            if (bus.start) begin
               if (bus.ro_mask != '0) begin
                  w_mask_nxt  = bus.ro_mask;
                  w_sel_nxt   = SEL_W'(w_first.idx);
                  w_state_nxt = StSettle;
                  w_tmr_load  = 1'b1;
                  w_tmr_value = LD_SETTLE;
                  w_clear_nxt = 1'b1;
                  w_busy_nxt  = 1'b1;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end
         StSettle: begin
            w_clear_nxt = 1'b1;
            if (w_tmr_expire) begin
               w_state_nxt  = StCount;
               w_tmr_load   = 1'b1;
               w_tmr_value  = LD_WINDOW;
               w_clear_nxt  = 1'b0;
               w_enable_nxt = 1'b1;
            end
         end
         StCount: begin
            w_enable_nxt = 1'b1;
            if (w_tmr_expire) begin
               w_enable_nxt = 1'b0;
               if (DRAIN > 0) begin
                  w_state_nxt = StDrain;
                  w_tmr_load  = 1'b1;
                  w_tmr_value = LD_DRAIN;
               end else begin
                  w_state_nxt = StCapture;
               end
            end
         end
         StDrain: begin
            if (w_tmr_expire) begin
               w_state_nxt = StCapture;
            end
         end
         StCapture: begin
            w_valid_nxt = 1'b1;
            w_idx_nxt   = r_sel;
            w_data_nxt  = bus.cnt_value;
            w_ovf_nxt   = &bus.cnt_value;
            if (w_next.found) begin
               w_sel_nxt   = SEL_W'(w_next.idx);
               w_state_nxt = StSettle;
               w_tmr_load  = 1'b1;
               w_tmr_value = LD_SETTLE;
               w_clear_nxt = 1'b1;
            end else begin
               w_state_nxt = StIdle;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_busy_nxt  = 1'b0;
         end
      endcase

      // Abort overrides everything outside IDLE and leaves the published result untouched.
      if ((r_state != StIdle) && bus.abort) begin
         w_state_nxt  = StIdle;
         w_sel_nxt    = r_sel;
         w_clear_nxt  = 1'b0;
         w_enable_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
         w_valid_nxt  = 1'b0;
         w_idx_nxt    = r_idx;
         w_data_nxt   = r_data;
         w_ovf_nxt    = r_ovf;
         w_done_nxt   = 1'b0;
         w_tmr_load   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_mask   <= '0;
         r_sel    <= '0;
         r_clear  <= 1'b0;
         r_enable <= 1'b0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_idx    <= '0;
         r_data   <= '0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_mask   <= w_mask_nxt;
         r_sel    <= w_sel_nxt;
         r_clear  <= w_clear_nxt;
         r_enable <= w_enable_nxt;
         r_busy   <= w_busy_nxt;
         r_valid  <= w_valid_nxt;
         r_idx    <= w_idx_nxt;
         r_data   <= w_data_nxt;
         r_ovf    <= w_ovf_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign bus.ro_sel       = r_sel;
   assign bus.cnt_clear    = r_clear;
   assign bus.cnt_enable   = r_enable;
   assign bus.busy         = r_busy;
   assign bus.result_valid = r_valid;
   assign bus.result_idx   = r_idx;
   assign bus.result_data  = r_data;
   assign bus.result_ovf   = r_ovf;
   assign bus.done         = r_done;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Scoreboard bench: stimulus queues expected results, a negedge monitor pops and compares.
module tb_ro_measure_ctrl;

   localparam int PER = 23;  // SETTLE + WINDOW + DRAIN + 1

   typedef struct {
      bit valid;
      bit done;
      int idx;
      int data;
      bit ovf;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   logic [15:0] cnt_tbl[4];
   int          en_run = 0;
   bit          en_chk = 1'b1;
   bit          sel_chk = 1'b0;

   ro_measure_ctrl_if #(.NUM_RO(4), .CNT_W(16)) bus ();

   ro_measure_ctrl #(
      .NUM_RO (4),
      .CNT_W  (16),
      .WINDOW (16),
      .SETTLE (4),
      .DRAIN  (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign bus.cnt_value = cnt_tbl[bus.ro_sel];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_res(input int idx, input int data, input bit ovf, input bit last,
                           input int at);
      exp_t e;
      e.valid = 1'b1; e.done = last; e.idx = idx; e.data = data; e.ovf = ovf; e.cyc = at;
      sb.push_back(e);
   endtask

   task automatic push_done(input int at);
      exp_t e;
      e.valid = 1'b0; e.done = 1'b1; e.idx = 0; e.data = 0; e.ovf = 1'b0; e.cyc = at;
      sb.push_back(e);
   endtask

   // Returns n = cycle number of the first SETTLE cycle; start deasserted by start_end.
   task automatic start_begin(input logic [3:0] m, output int n);
      @(negedge clk);
      bus.ro_mask = m;
      bus.start   = 1'b1;
      n = cyc + 1;
   endtask

   task automatic start_end();
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_sb(input int budget);
      int t = 0;
      while (sb.size() != 0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("sb_drain", sb.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ro_sel"}, bus.ro_sel, 0);
      check({tag, "_cnt_clear"}, bus.cnt_clear, 0);
      check({tag, "_cnt_enable"}, bus.cnt_enable, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_result_valid"}, bus.result_valid, 0);
      check({tag, "_result_idx"}, bus.result_idx, 0);
      check({tag, "_result_data"}, bus.result_data, 0);
      check({tag, "_result_ovf"}, bus.result_ovf, 0);
      check({tag, "_done"}, bus.done, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.result_valid || bus.done) begin
            if (sb.size() == 0) begin
               check("unexpected_output", {30'd0, bus.result_valid, bus.done}, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check("result_valid", bus.result_valid, mon_e.valid);
               check("done", bus.done, mon_e.done);
               check("event_cycle", cyc, mon_e.cyc);
               if (mon_e.done) check("busy_at_done", bus.busy, 0);
               if (mon_e.valid) begin
                  check("result_idx", bus.result_idx, mon_e.idx);
                  check("result_data", bus.result_data, mon_e.data);
                  check("result_ovf", bus.result_ovf, mon_e.ovf);
               end
            end
         end
         if (bus.cnt_enable) begin
            en_run++;
         end else begin
            if (en_run != 0 && en_chk) check("enable_window", en_run, 16);
            en_run = 0;
         end
         if (sel_chk && bus.busy) check("sparse_sel", (bus.ro_sel == 1 || bus.ro_sel == 3), 1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.ro_mask = '0;
      cnt_tbl[0] = 16'd0; cnt_tbl[1] = 16'd100; cnt_tbl[2] = 16'd200; cnt_tbl[3] = 16'd300;

      // Reset state
      repeat (3) @(negedge clk);
      check_zero("in_reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_zero("after_reset");

      // Full sweep
      start_begin(4'b1111, n);
      for (int i = 0; i < 4; i++) push_res(i, i * 100, 1'b0, i == 3, n + PER * (i + 1));
      start_end();
      check("sweep_busy", bus.busy, 1);
      check("sweep_clear", bus.cnt_clear, 1);
      check("sweep_sel0", bus.ro_sel, 0);
      wait_sb(200);

      // Sparse mask
      sel_chk = 1'b1;
      start_begin(4'b1010, n);
      push_res(1, 100, 1'b0, 1'b0, n + PER);
      push_res(3, 300, 1'b0, 1'b1, n + 2 * PER);
      start_end();
      check("sparse_first_sel", bus.ro_sel, 1);
      wait_sb(100);
      sel_chk = 1'b0;

      // Empty mask
      start_begin(4'b0000, n);
      push_done(n);
      start_end();
      check("empty_busy0", bus.busy, 0);
      repeat (5) begin
         @(negedge clk);
         check("empty_busy_idle", bus.busy, 0);
      end
      wait_sb(10);

      // Abort during COUNT of the second oscillator
      en_chk = 1'b0;
      start_begin(4'b1111, n);
      push_res(0, 0, 1'b0, 1'b0, n + PER);
      start_end();
      repeat (29) @(negedge clk);
      check("abort_pre_enable", bus.cnt_enable, 1);
      check("abort_pre_sel", bus.ro_sel, 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_enable", bus.cnt_enable, 0);
      check("abort_clear", bus.cnt_clear, 0);
      repeat (40) @(negedge clk);
      check("abort_sb_empty", sb.size(), 0);
      en_chk = 1'b1;
      start_begin(4'b1111, n);
      for (int i = 0; i < 4; i++) push_res(i, i * 100, 1'b0, i == 3, n + PER * (i + 1));
      start_end();
      wait_sb(200);

      // Overflow plus ignored start mid-sweep
      cnt_tbl[2] = 16'hFFFF;
      start_begin(4'b1111, n);
      push_res(0, 0, 1'b0, 1'b0, n + PER);
      push_res(1, 100, 1'b0, 1'b0, n + 2 * PER);
      push_res(2, 16'hFFFF, 1'b1, 1'b0, n + 3 * PER);
      push_res(3, 300, 1'b0, 1'b1, n + 4 * PER);
      start_end();
      repeat (10) @(negedge clk);
      bus.ro_mask = 4'b0001;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_start_busy", bus.busy, 1);
      wait_sb(200);
      cnt_tbl[2] = 16'd200;

      // Asynchronous reset mid-COUNT
      en_chk = 1'b0;
      start_begin(4'b1111, n);
      start_end();
      repeat (8) @(negedge clk);
      check("rst_pre_enable", bus.cnt_enable, 1);
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("post_rst_busy", bus.busy, 0);
      check("post_rst_enable", bus.cnt_enable, 0);
      check("post_rst_clear", bus.cnt_clear, 0);
      check("post_rst_sb_empty", sb.size(), 0);
      en_chk = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
